// File: rtl/conversor_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Define CONVERSOR_BCD_SINAL_EN for two's-complement input with a Negativo sign output.
module conversor_bcd_serial #(
    parameter int LARGURA = 8,
    parameter int DIGITOS = 3
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   Inicio,
    input  logic [LARGURA-1:0]     Binario,
    output logic                   Ocupado,
    output logic                   Pronto,
    output logic [4*DIGITOS-1:0]   BCD,
`ifdef CONVERSOR_BCD_SINAL_EN
    output logic                   Negativo,
`endif
    output logic [1:0]             estado_o
);

    localparam int BW = 4 * DIGITOS;
    localparam int CW = $clog2(LARGURA + 1);

    // Decimal digit count of 2^largura-1, i.e. ceil(largura*log10(2)).
    function automatic int min_digitos(input int largura);
        longint unsigned v;
        int              d;
        v = (64'd1 << largura) - 64'd1;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                d++;
                v = v / 10;
            end
        end
        return d;
    endfunction

    if (LARGURA < 4 || LARGURA > 32) begin : g_err_largura
        $error("conversor_bcd_serial: LARGURA must be in 4..32");
    end
    if (DIGITOS < min_digitos(LARGURA)) begin : g_err_digitos
        $error("conversor_bcd_serial: DIGITOS too small for LARGURA");
    end

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    estado_t              estado_q;
    logic [LARGURA-1:0]   desloc_q;
    logic [BW-1:0]        trab_q;
    logic [BW-1:0]        bcd_q;
    logic [CW-1:0]        cont_q;
    logic                 ocupado_q;
    logic                 pronto_q;

    logic [LARGURA-1:0]   magnitude;
    logic [BW-1:0]        trab_corr;
    logic [BW+LARGURA-1:0] conc;
    logic [BW-1:0]        trab_d;
    logic [LARGURA-1:0]   desloc_d;

`ifdef CONVERSOR_BCD_SINAL_EN
    logic sinal_q;
    logic negativo_q;
    // Unsigned negation: the most negative value maps to 2^(LARGURA-1).
    assign magnitude = Binario[LARGURA-1] ? (~Binario + LARGURA'(1)) : Binario;
    assign Negativo  = negativo_q;
`else
    assign magnitude = Binario;
`endif

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    always_comb begin
        trab_corr = trab_q;
        for (int k = 0; k < DIGITOS; k++) begin
            if (trab_q[4*k +: 4] >= 4'd5) begin
                trab_corr[4*k +: 4] = trab_q[4*k +: 4] + 4'd3;
            end
        end
        conc = {trab_corr, desloc_q} << 1;
    end

    assign trab_d   = conc[BW+LARGURA-1:LARGURA];
    assign desloc_d = conc[LARGURA-1:0];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q   <= OCIOSO;
            desloc_q   <= '0;
            trab_q     <= '0;
            bcd_q      <= '0;
            cont_q     <= '0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
`ifdef CONVERSOR_BCD_SINAL_EN
            sinal_q    <= 1'b0;
            negativo_q <= 1'b0;
`endif
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (Inicio) begin
                        desloc_q  <= magnitude;
                        trab_q    <= '0;
                        cont_q    <= CW'(LARGURA);
                        ocupado_q <= 1'b1;
`ifdef CONVERSOR_BCD_SINAL_EN
                        sinal_q   <= Binario[LARGURA-1];
`endif
                        estado_q  <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    trab_q   <= trab_d;
                    desloc_q <= desloc_d;
                    cont_q   <= cont_q - CW'(1);
                    if (cont_q == CW'(1)) begin
                        estado_q <= FIM;
                    end
                end
                FIM: begin
                    bcd_q      <= trab_q;
                    pronto_q   <= 1'b1;
                    ocupado_q  <= 1'b0;
`ifdef CONVERSOR_BCD_SINAL_EN
                    negativo_q <= sinal_q;
`endif
                    estado_q   <= OCIOSO;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign Ocupado  = ocupado_q;
    assign Pronto   = pronto_q;
    assign BCD      = bcd_q;
    assign estado_o = estado_q;

endmodule

// File: tb/tb_conversor_bcd_serial.sv
// Bench for conversor_bcd_serial: 8-bit/3-digit instance checked every cycle against
// an arithmetic model, plus a 16-bit/5-digit instance with directed checks.
module tb_conversor_bcd_serial;

    localparam int L = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0;
    logic [7:0]  binario = '0;
    logic        ocupado, pronto;
    logic [11:0] bcd;
    logic [1:0]  estado;

    logic        inicio_b = 1'b0;
    logic [15:0] bin_b = '0;
    logic        ocupado_b, pronto_b;
    logic [19:0] bcd_b;
    logic [1:0]  estado_b;
`ifdef CONVERSOR_BCD_SINAL_EN
    logic        negativo, negativo_b;
`endif

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    conversor_bcd_serial #(.LARGURA(8), .DIGITOS(3)) dut_a (
        .Clock(clk), .Reset_n(rst_n), .Inicio(inicio), .Binario(binario),
        .Ocupado(ocupado), .Pronto(pronto), .BCD(bcd),
`ifdef CONVERSOR_BCD_SINAL_EN
        .Negativo(negativo),
`endif
        .estado_o(estado)
    );

    conversor_bcd_serial #(.LARGURA(16), .DIGITOS(5)) dut_b (
        .Clock(clk), .Reset_n(rst_n), .Inicio(inicio_b), .Binario(bin_b),
        .Ocupado(ocupado_b), .Pronto(pronto_b), .BCD(bcd_b),
`ifdef CONVERSOR_BCD_SINAL_EN
        .Negativo(negativo_b),
`endif
        .estado_o(estado_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Model helpers: plain decimal arithmetic.
    function automatic logic [31:0] to_bcd(input longint unsigned v);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic longint unsigned mag_of(input longint unsigned v, input int w);
`ifdef CONVERSOR_BCD_SINAL_EN
        if (v >= (64'd1 << (w - 1))) return (64'd1 << w) - v;
`endif
        return v;
    endfunction

    function automatic bit sign_of(input longint unsigned v, input int w);
`ifdef CONVERSOR_BCD_SINAL_EN
        return v >= (64'd1 << (w - 1));
`else
        return (w < 0) && (v == 0);
`endif
    endfunction

    // Reference: a conversion accepted on an edge completes LARGURA+1 edges later.
    logic [31:0]     m_bcd = '0;
    bit              m_pronto = 1'b0, m_busy = 1'b0, m_neg = 1'b0, m_sign = 1'b0;
    int              m_left = 0;
    longint unsigned m_val = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bcd = '0; m_pronto = 1'b0; m_busy = 1'b0; m_neg = 1'b0; m_left = 0;
        end else begin
            m_pronto = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd    = to_bcd(m_val);
                    m_neg    = m_sign;
                    m_pronto = 1'b1;
                end
            end else if (inicio) begin
                m_val  = mag_of(binario, L);
                m_sign = sign_of(binario, L);
                m_left = L + 1;
            end
            m_busy = (m_left > 0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_pronto", pronto, m_pronto);
            check("cyc_ocupado", ocupado, m_busy);
            check("cyc_bcd", bcd, m_bcd[11:0]);
`ifdef CONVERSOR_BCD_SINAL_EN
            check("cyc_negativo", negativo, m_neg);
`endif
        end
    end

    task automatic wait_a(input string name, input logic [11:0] exp_bcd, input bit exp_neg,
                          input bit drop, input bit chg, input logic [7:0] chg_val);
        int e, busy;
        bit got;
        e = 0; busy = 0; got = 1'b0;
        while (!got && e < 40) begin
            @(negedge clk);
            e++;
            if (e == 1 && drop) inicio = 1'b0;
            if (e == 4 && chg) binario = chg_val;
            if (ocupado) busy++;
            if (pronto) got = 1'b1;
        end
        check({name, "_done"}, got, 1);
        check({name, "_lat"}, e - 1, L + 1);
        check({name, "_busy"}, busy, L + 1);
        check({name, "_bcd"}, bcd, exp_bcd);
`ifdef CONVERSOR_BCD_SINAL_EN
        check({name, "_neg"}, negativo, exp_neg);
`else
        check({name, "_negexp"}, exp_neg, 0);
`endif
        if (drop) begin
            @(negedge clk);
            check({name, "_pulse"}, pronto, 0);
            check({name, "_hold"}, bcd, exp_bcd);
        end
    endtask

    task automatic run_a(input string name, input logic [7:0] v, input logic [11:0] exp_bcd,
                         input bit exp_neg);
        @(negedge clk);
        inicio = 1'b1;
        binario = v;
        wait_a(name, exp_bcd, exp_neg, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic run_b(input string name, input logic [15:0] v, input logic [19:0] exp_bcd,
                         input bit exp_neg);
        int e, busy;
        bit got;
        @(negedge clk);
        inicio_b = 1'b1;
        bin_b = v;
        e = 0; busy = 0; got = 1'b0;
        while (!got && e < 60) begin
            @(negedge clk);
            e++;
            if (e == 1) inicio_b = 1'b0;
            if (ocupado_b) busy++;
            if (pronto_b) got = 1'b1;
        end
        check({name, "_done"}, got, 1);
        check({name, "_lat"}, e - 1, 17);
        check({name, "_busy"}, busy, 17);
        check({name, "_bcd"}, bcd_b, exp_bcd);
`ifdef CONVERSOR_BCD_SINAL_EN
        check({name, "_neg"}, negativo_b, exp_neg);
`else
        check({name, "_negexp"}, exp_neg, 0);
`endif
    endtask

    initial begin
        int pc;
        repeat (2) @(negedge clk);
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_bcd", bcd, 12'h000);
        check("rst_bcd_b", bcd_b, 20'h00000);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Model pins against hand-computed decimal values.
        check("model_255", to_bcd(255), 32'h255);
        check("model_65535", to_bcd(65535), 32'h65535);

        run_a("zero", 8'd0, 12'h000, 1'b0);
        run_a("cem", 8'd100, 12'h100, 1'b0);
        run_a("nove", 8'd9, 12'h009, 1'b0);
        run_a("c59", 8'd59, 12'h059, 1'b0);
`ifdef CONVERSOR_BCD_SINAL_EN
        run_a("s80", 8'h80, 12'h128, 1'b1);
        run_a("sff", 8'hFF, 12'h001, 1'b1);
        run_a("s7f", 8'h7F, 12'h127, 1'b0);
        run_a("s9c", 8'h9C, 12'h100, 1'b1);
`else
        run_a("u255", 8'd255, 12'h255, 1'b0);
        run_a("u128", 8'd128, 12'h128, 1'b0);
        run_a("u127", 8'd127, 12'h127, 1'b0);
        run_a("u254", 8'd254, 12'h254, 1'b0);
`endif

        // Inicio held high, Binario changed mid-run; back-to-back second conversion.
        @(negedge clk);
        inicio = 1'b1;
        binario = 8'd37;
        wait_a("hold37", 12'h037, 1'b0, 1'b0, 1'b1, 8'd200);
`ifdef CONVERSOR_BCD_SINAL_EN
        wait_a("next200", 12'h056, 1'b1, 1'b1, 1'b0, 8'd0);
`else
        wait_a("next200", 12'h200, 1'b0, 1'b1, 1'b0, 8'd0);
`endif

        // Asynchronous reset in the 4th CONVERTE cycle.
        @(negedge clk);
        inicio = 1'b1;
        binario = 8'd99;
        @(negedge clk);
        inicio = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ocupado", ocupado, 0);
        check("arst_pronto", pronto, 0);
        check("arst_bcd", bcd, 12'h000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        pc = 0;
        repeat (14) begin
            @(negedge clk);
            if (pronto) pc++;
        end
        check("arst_no_pronto", pc, 0);
        run_a("after_rst42", 8'd42, 12'h042, 1'b0);

`ifdef CONVERSOR_BCD_SINAL_EN
        run_b("b_ffff", 16'hFFFF, 20'h00001, 1'b1);
        run_b("b_40000", 16'd40000, 20'h25536, 1'b1);
`else
        run_b("b_ffff", 16'hFFFF, 20'h65535, 1'b0);
        run_b("b_40000", 16'd40000, 20'h40000, 1'b0);
`endif
        run_b("b_1000", 16'd1000, 20'h01000, 1'b0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
